// File: rtl/guess_seq_ctrl.sv
// guess_seq_ctrl
// Sequencer for the 4-digit xAyB guess-number game. It sits between the
// keypad decoder and the dot-matrix display driver. It collects the four
// secret digits, then collects repeated four-digit guesses. Each guess is
// scored as bulls (r_a) and cows (r_b), and the score is shown with a
// blinking display enable.
//
// Ports
//   clk_div      in   clock (divided system clock)
//   reset        in   asynchronous, active-low reset
//   key_valid    in   one-cycle strobe, key_code valid
//   key_code     in   [3:0] digit code, 0-9 legal, 10-15 ignored
//   key_clear    in   one-cycle strobe: restart entry / new game from WIN
//   digit_state  out  [1:0] index of the digit being entered
//   qa_state     out  0 = entering secret, 1 = entering guess
//   match        out  1 while a scored result is displayed
//   show         out  display enable during result (blinks)
//   r_a          out  [2:0] bulls of last guess
//   r_b          out  [2:0] cows of last guess
//   guess_count  out  [3:0] scored guesses this game, saturating at 15
module guess_seq_ctrl #(
    parameter int BLINK_CYCLES  = 64,
    parameter int RESULT_HALVES = 6
) (
    input  logic       clk_div,
    input  logic       reset,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    input  logic       key_clear,
    output logic [1:0] digit_state,
    output logic       qa_state,
    output logic       match,
    output logic       show,
    output logic [2:0] r_a,
    output logic [2:0] r_b,
    output logic [3:0] guess_count
);

    localparam int TW = (BLINK_CYCLES > 2) ? $clog2(BLINK_CYCLES) : 1;
    localparam int HW = $clog2(RESULT_HALVES + 1);

    typedef enum logic [2:0] {
        Q_ENTRY,
        A_ENTRY,
        COMPARE,
        RESULT,
        WIN
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      digit_q, digit_d;
    logic            qa_q, qa_d;
    logic            match_q, match_d;
    logic            show_q, show_d;
    logic [2:0]      ra_q, ra_d;
    logic [2:0]      rb_q, rb_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [HW-1:0]   half_q, half_d;
    logic [3:0][3:0] secret_q, secret_d;
    logic [3:0][3:0] guess_q, guess_d;

    logic            entry;
    logic            dup;
    logic            accept;
    logic            timer_term;
    logic [3:0][3:0] cur_slots;
    logic [2:0]      bulls;
    logic [2:0]      cows;

    // Score the stored guess against the secret. Digits within each phase
    // are kept distinct by the duplicate filter, so every guess digit can
    // match at most one secret digit.
    always_comb begin
        bulls = '0;
        cows  = '0;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                if (guess_q[i] == secret_q[j]) begin
                    if (i == j) bulls = bulls + 3'd1;
                    else        cows  = cows + 3'd1;
                end
            end
        end
    end

    // A key is accepted only when it is a legal digit. It must also not repeat
    // a digit already entered in the current phase. Only slots below
    // digit_state are valid. Slots left over after a clear are stale.
    always_comb begin
        entry     = (state_q == Q_ENTRY) || (state_q == A_ENTRY);
        cur_slots = (state_q == A_ENTRY) ? guess_q : secret_q;
        dup       = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if ((i < int'(digit_q)) && (cur_slots[i] == key_code)) dup = 1'b1;
        end
        accept = entry && key_valid && !key_clear && (key_code <= 4'd9) && !dup;
    end

    assign timer_term = (timer_q == TW'(BLINK_CYCLES - 1));

    always_comb begin
        state_d  = state_q;
        digit_d  = digit_q;
        qa_d     = qa_q;
        match_d  = match_q;
        show_d   = show_q;
        ra_d     = ra_q;
        rb_d     = rb_q;
        cnt_d    = cnt_q;
        timer_d  = timer_q;
        half_d   = half_q;
        secret_d = secret_q;
        guess_d  = guess_q;

        case (state_q)
            Q_ENTRY, A_ENTRY: begin
                if (key_clear) begin
                    digit_d = 2'd0;
                end else if (accept) begin
                    if (state_q == Q_ENTRY) secret_d[digit_q] = key_code;
                    else                    guess_d[digit_q]  = key_code;
                    if (digit_q != 2'd3) begin
                        digit_d = digit_q + 2'd1;
                    end else if (state_q == Q_ENTRY) begin
                        state_d = A_ENTRY;
                        qa_d    = 1'b1;
                        digit_d = 2'd0;
                    end else begin
                        // digit_state stays at 3 through scoring and display
                        state_d = COMPARE;
                    end
                end
            end

            COMPARE: begin
                ra_d    = bulls;
                rb_d    = cows;
                cnt_d   = (cnt_q == 4'd15) ? cnt_q : cnt_q + 4'd1;
                match_d = 1'b1;
                show_d  = 1'b1;
                timer_d = '0;
                half_d  = '0;
                state_d = RESULT;
            end

            RESULT: begin
                if (timer_term) begin
                    timer_d = '0;
                    show_d  = !show_q;
                    half_d  = half_q + HW'(1);
                    if (half_q == HW'(RESULT_HALVES - 1)) begin
                        if (ra_q == 3'd4) begin
                            // Solved: keep blinking in WIN.
                            state_d = WIN;
                        end else begin
                            state_d = A_ENTRY;
                            match_d = 1'b0;
                            show_d  = 1'b0;
                            digit_d = 2'd0;
                        end
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end

            WIN: begin
                if (key_clear) begin
                    state_d = Q_ENTRY;
                    qa_d    = 1'b0;
                    digit_d = 2'd0;
                    match_d = 1'b0;
                    show_d  = 1'b0;
                    ra_d    = '0;
                    rb_d    = '0;
                    cnt_d   = '0;
                    timer_d = '0;
                    half_d  = '0;
                end else if (timer_term) begin
                    timer_d = '0;
                    show_d  = !show_q;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end

            default: state_d = Q_ENTRY;
        endcase
    end

    always_ff @(posedge clk_div or negedge reset) begin
        if (!reset) begin
            state_q  <= Q_ENTRY;
            digit_q  <= '0;
            qa_q     <= 1'b0;
            match_q  <= 1'b0;
            show_q   <= 1'b0;
            ra_q     <= '0;
            rb_q     <= '0;
            cnt_q    <= '0;
            timer_q  <= '0;
            half_q   <= '0;
            secret_q <= '0;
            guess_q  <= '0;
        end else begin
            state_q  <= state_d;
            digit_q  <= digit_d;
            qa_q     <= qa_d;
            match_q  <= match_d;
            show_q   <= show_d;
            ra_q     <= ra_d;
            rb_q     <= rb_d;
            cnt_q    <= cnt_d;
            timer_q  <= timer_d;
            half_q   <= half_d;
            secret_q <= secret_d;
            guess_q  <= guess_d;
        end
    end

    assign digit_state = digit_q;
    assign qa_state    = qa_q;
    assign match       = match_q;
    assign show        = show_q;
    assign r_a         = ra_q;
    assign r_b         = rb_q;
    assign guess_count = cnt_q;

endmodule
